// File: rtl/cop_sprite_pkg.sv
// Shared sizes, transparency key, fetch FSM states and frame base-address helper for the cop sprite fetcher.
// No timing of its own: pure constants and combinational helpers.
package cop_sprite_pkg;
   localparam int SPR_W    = 68;
   localparam int SPR_H    = 64;
   localparam int N_FRAMES = 4;
   localparam int ADDR_W   = 15;
   localparam int V_TOTAL  = 525;
   localparam int H_ACTIVE = 640;
   localparam int COL_W    = 7;
   localparam int ROW_W    = 6;
   localparam logic [23:0] KEY_RGB = 24'h00ff00;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;

   function automatic logic [ADDR_W-1:0] spr_base(input logic [1:0] frame);
      return ADDR_W'(frame) * ADDR_W'(SPR_W * SPR_H);
   endfunction
endpackage

// File: rtl/cop_sprite_fetcher_if.sv
// Signal bundle between the VGA/ROM side (master) and the sprite fetcher (slave); no flow control, all 1-cycle.
// COP_SPRITE_MIRROR_EN adds the mirror input sampled at line_start.
interface cop_sprite_fetcher_if
   import cop_sprite_pkg::*;
;
   logic              line_start;
   logic [9:0]        DrawX;
   logic [9:0]        DrawY;
   logic [9:0]        spr_x;
   logic [9:0]        spr_y;
   logic [1:0]        frame_sel;
`ifdef COP_SPRITE_MIRROR_EN
   logic              mirror;
`endif
   logic [ADDR_W-1:0] rom_addr;
   logic [23:0]       rom_data;
   logic [23:0]       pix_rgb;
   logic              pix_valid;
   logic              busy;

   modport master (
      output line_start, DrawX, DrawY, spr_x, spr_y, frame_sel,
`ifdef COP_SPRITE_MIRROR_EN
      output mirror,
`endif
      output rom_data,
      input  rom_addr, pix_rgb, pix_valid, busy
   );

   modport slave (
      input  line_start, DrawX, DrawY, spr_x, spr_y, frame_sel,
`ifdef COP_SPRITE_MIRROR_EN
      input  mirror,
`endif
      input  rom_data,
      output rom_addr, pix_rgb, pix_valid, busy
   );
endinterface

// File: rtl/cop_line_buffer.sv
// Ping-pong sprite line buffer: back bank written by the fetcher, front bank read by the display path.
// Combinational read, registered write; no backpressure (writer owns back bank until swap).
module cop_line_buffer
   import cop_sprite_pkg::*;
(
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             swap_i,
   input  logic             abort_i,
   input  logic             done_i,
   input  logic             wr_en_i,
   input  logic [COL_W-1:0] wr_col_i,
   input  logic [23:0]      wr_dat_i,
   input  logic [COL_W-1:0] rd_col_i,
   output logic [23:0]      rd_dat_o,
   output logic             rd_vld_o
);
   logic        fsel_d, fsel_q;
   logic [1:0]  valid_d, valid_q;
   logic [23:0] mem_q [2][SPR_W];

   // Abort kills the half-filled back bank before the swap exposes it; the bank
   // leaving the front is cleared because it is about to be refilled or unused.
   always_comb begin
      fsel_d  = fsel_q;
      valid_d = valid_q;
      if (done_i)  valid_d[~fsel_q] = 1'b1;
      if (abort_i) valid_d[~fsel_q] = 1'b0;
      if (swap_i) begin
         valid_d[fsel_q] = 1'b0;
         fsel_d          = ~fsel_q;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         fsel_q  <= 1'b0;
         valid_q <= 2'b00;
      end else begin
         fsel_q  <= fsel_d;
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (wr_en_i) mem_q[~fsel_q][wr_col_i] <= wr_dat_i;
   end

   assign rd_dat_o = (rd_col_i < COL_W'(SPR_W)) ? mem_q[fsel_q][rd_col_i] : 24'h0;
   assign rd_vld_o = valid_q[fsel_q];
endmodule

// File: rtl/cop_sprite_fetcher.sv
// Prefetches one sprite row per line into a ping-pong buffer (SPR_W+1 cycles) and emits registered pixels (1-cycle latency).
// No backpressure; a new line_start aborts any fetch in progress. COP_SPRITE_MIRROR_EN enables horizontal flip.
module cop_sprite_fetcher
   import cop_sprite_pkg::*;
(
   input logic                 Clk,
   input logic                 Reset_n,
   cop_sprite_fetcher_if.slave bus
);
   fetch_state_t      fsm_d, fsm_q;
   logic [COL_W-1:0]  col_d, col_q, wr_col_d, wr_col_q;
   logic [COL_W-1:0]  start_col, next_col, rd_col;
   logic [ROW_W-1:0]  row_d, row_q;
   logic [1:0]        frame_d, frame_q, frame_clamp;
   logic [9:0]        spr_x_d, spr_x_q;
   logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;
   logic              wr_vld_d, wr_vld_q;
   logic [23:0]       pix_rgb_d, pix_rgb_q, rd_dat;
   logic              pix_valid_d, pix_valid_q, rd_vld;
   logic              swap, abort, done, in_rng, hit;
   logic [10:0]       tgt;

   function automatic logic [ADDR_W-1:0] addr_of(input logic [1:0] fr,
                                                  input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
      return spr_base(fr) + ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col);
   endfunction

   generate
      if (N_FRAMES < 4) begin : g_clamp
         assign frame_clamp = (bus.frame_sel >= 2'(N_FRAMES)) ? 2'(N_FRAMES - 1) : bus.frame_sel;
      end else begin : g_noclamp
         assign frame_clamp = bus.frame_sel;
      end
   endgenerate

`ifdef COP_SPRITE_MIRROR_EN
   logic mirror_d, mirror_q;
   assign mirror_d  = bus.line_start ? bus.mirror : mirror_q;
   assign start_col = bus.mirror ? COL_W'(SPR_W - 1) : '0;
   assign next_col  = mirror_q ? COL_W'(SPR_W - 2) - col_q : col_q + 7'd1;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) mirror_q <= 1'b0;
      else          mirror_q <= mirror_d;
   end
`else
   assign start_col = '0;
   assign next_col  = col_q + 7'd1;
`endif

   // The line being prefetched is the one after DrawY, wrapping at the frame end.
   assign tgt    = (bus.DrawY == 10'(V_TOTAL - 1)) ? 11'd0 : {1'b0, bus.DrawY} + 11'd1;
   assign in_rng = (tgt >= {1'b0, bus.spr_y}) && (tgt < {1'b0, bus.spr_y} + 11'(SPR_H));

   always_comb begin
      fsm_d      = fsm_q;
      col_d      = col_q;
      row_d      = row_q;
      frame_d    = frame_q;
      spr_x_d    = spr_x_q;
      rom_addr_d = rom_addr_q;
      wr_vld_d   = 1'b0;
      wr_col_d   = col_q;
      swap       = 1'b0;
      abort      = 1'b0;
      done       = 1'b0;
      case (fsm_q)
         FETCH: begin
            wr_vld_d = 1'b1;
            if (col_q == COL_W'(SPR_W - 1)) begin
               fsm_d = DRAIN;
            end else begin
               col_d      = col_q + 7'd1;
               rom_addr_d = addr_of(frame_q, row_q, next_col);
            end
         end
         DRAIN: begin
            done  = 1'b1;
            fsm_d = IDLE;
         end
         default: ;
      endcase
      if (bus.line_start) begin
         swap     = 1'b1;
         abort    = (fsm_q != IDLE);
         done     = 1'b0;
         wr_vld_d = 1'b0;
         spr_x_d  = bus.spr_x;
         frame_d  = frame_clamp;
         if (in_rng) begin
            fsm_d      = FETCH;
            col_d      = '0;
            row_d      = ROW_W'(tgt - {1'b0, bus.spr_y});
            rom_addr_d = addr_of(frame_clamp, ROW_W'(tgt - {1'b0, bus.spr_y}), start_col);
         end else begin
            fsm_d = IDLE;
         end
      end
   end

   assign rd_col = COL_W'({1'b0, bus.DrawX} - {1'b0, spr_x_q});
   assign hit    = ({1'b0, bus.DrawX} >= {1'b0, spr_x_q}) &&
                   ({1'b0, bus.DrawX} <  {1'b0, spr_x_q} + 11'(SPR_W)) &&
                   (bus.DrawX < 10'(H_ACTIVE));

   always_comb begin
      pix_valid_d = hit && rd_vld && (rd_dat != KEY_RGB);
      pix_rgb_d   = pix_valid_d ? rd_dat : 24'h0;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         fsm_q       <= IDLE;
         col_q       <= '0;
         row_q       <= '0;
         frame_q     <= '0;
         spr_x_q     <= '0;
         rom_addr_q  <= '0;
         wr_vld_q    <= 1'b0;
         wr_col_q    <= '0;
         pix_rgb_q   <= '0;
         pix_valid_q <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         col_q       <= col_d;
         row_q       <= row_d;
         frame_q     <= frame_d;
         spr_x_q     <= spr_x_d;
         rom_addr_q  <= rom_addr_d;
         wr_vld_q    <= wr_vld_d;
         wr_col_q    <= wr_col_d;
         pix_rgb_q   <= pix_rgb_d;
         pix_valid_q <= pix_valid_d;
      end
   end

   cop_line_buffer u_buf (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .swap_i   (swap),
      .abort_i  (abort),
      .done_i   (done),
      .wr_en_i  (wr_vld_q),
      .wr_col_i (wr_col_q),
      .wr_dat_i (bus.rom_data),
      .rd_col_i (rd_col),
      .rd_dat_o (rd_dat),
      .rd_vld_o (rd_vld)
   );

   assign bus.rom_addr  = rom_addr_q;
   assign bus.pix_rgb   = pix_rgb_q;
   assign bus.pix_valid = pix_valid_q;
   assign bus.busy      = (fsm_q != IDLE);
endmodule

// File: tb/tb_cop_sprite_fetcher.sv
// Bench for cop_sprite_fetcher: {frame,row,col}-coded ROM, line-level reference model, randomized placements.
// COP_SPRITE_MIRROR_EN additionally exercises the mirrored fetch order.
module tb_cop_sprite_fetcher;
   localparam logic [23:0] KEY = 24'h00ff00;

   logic Clk = 1'b0;
   logic Reset_n = 1'b1;
   always #5 Clk = ~Clk;

   cop_sprite_fetcher_if bus ();
   cop_sprite_fetcher dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int key_col = -1;
   always @(posedge Clk) cyc <= cyc + 1;

   function automatic logic [23:0] rom_word(input int addr);
      int fr  = addr / 4352;
      int rem = addr % 4352;
      int row = rem / 68;
      int col = rem % 68;
      if (col == key_col) return KEY;
      return {8'(fr), 8'(row), 8'(col)};
   endfunction

   always @(posedge Clk) bus.rom_data <= rom_word(int'(bus.rom_addr));

   // Reference: which sprite row each bank holds, one step per line_start.
   bit f_vld, b_vld, b_pend, f_mir, b_mir;
   int f_fr, f_row, b_fr, b_row, m_sx, last_pulse;

   task automatic model_reset();
      f_vld = 0; b_vld = 0; b_pend = 0;
   endtask

   task automatic model_pulse(input int dy, sx, sy, fr, mir, now);
      int tgt = (dy == 524) ? 0 : dy + 1;
      if (b_pend && (now - last_pulse) >= 70) b_vld = 1;
      f_vld = b_vld; f_fr = b_fr; f_row = b_row; f_mir = b_mir;
      m_sx = sx;
      last_pulse = now;
      b_vld = 0;
      if (tgt >= sy && tgt < sy + 64) begin
         b_pend = 1; b_fr = fr; b_row = tgt - sy; b_mir = (mir != 0);
      end else begin
         b_pend = 0;
      end
   endtask

   task automatic tick();
      @(posedge Clk); #1;
   endtask

   task automatic pulse(input int dy, sx, sy, fr, mir);
      int m = mir;
`ifndef COP_SPRITE_MIRROR_EN
      m = 0;
`endif
      bus.DrawY = 10'(dy); bus.spr_x = 10'(sx); bus.spr_y = 10'(sy); bus.frame_sel = 2'(fr);
`ifdef COP_SPRITE_MIRROR_EN
      bus.mirror = (mir != 0);
`endif
      bus.line_start = 1'b1;
      tick();
      bus.line_start = 1'b0;
      model_pulse(dy, sx, sy, fr, m, cyc);
   endtask

   task automatic check_fetch(input int fr, row, mir);
      int k = 0;
      for (int i = 0; i < 200; i++) begin
         if (bus.busy !== 1'b1) break;
         if (k < 68) begin
            int c = (mir != 0) ? 67 - k : k;
            n_chk++;
            if (bus.rom_addr !== 15'(fr * 4352 + row * 68 + c)) begin
               n_fail++;
               $display("FAIL fetch_addr k=%0d got %0d want %0d", k, bus.rom_addr, fr * 4352 + row * 68 + c);
            end
         end
         k++;
         tick();
      end
      n_chk++;
      if (k != 69) begin
         n_fail++;
         $display("FAIL busy_len got %0d want 69", k);
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300; i++) begin
         if (bus.busy === 1'b0) return;
         tick();
      end
      n_chk++; n_fail++;
      $display("FAIL wait_idle timeout busy=%b want 0", bus.busy);
   endtask

   task automatic sweep(input int x0, x1);
      for (int x = (x0 < 0 ? 0 : x0); x <= x1 && x < 1024; x++) begin
         logic [23:0] w, er;
         logic ev;
         int col;
         bus.DrawX = 10'(x);
         tick();
         col = x - m_sx;
         ev = 0; er = 0;
         if (f_vld && x >= m_sx && x < m_sx + 68 && x < 640) begin
            w = rom_word(f_fr * 4352 + f_row * 68 + (f_mir ? 67 - col : col));
            if (w != KEY) begin ev = 1; er = w; end
         end
         n_chk++;
         if (bus.pix_valid !== ev || bus.pix_rgb !== er) begin
            n_fail++;
            $display("FAIL pixel x=%0d got v=%b rgb=%h want v=%b rgb=%h", x, bus.pix_valid, bus.pix_rgb, ev, er);
         end
      end
   endtask

   task automatic probe(input int x, input logic ev, input logic [23:0] er, input string nm);
      bus.DrawX = 10'(x);
      tick();
      n_chk++;
      if (bus.pix_valid !== ev || bus.pix_rgb !== er) begin
         n_fail++;
         $display("FAIL %s x=%0d got v=%b rgb=%h want v=%b rgb=%h", nm, x, bus.pix_valid, bus.pix_rgb, ev, er);
      end
   endtask

   task automatic test_reset();
      #2 Reset_n = 1'b0;
      repeat (2) tick();
      n_chk += 4;
      if (bus.rom_addr !== 15'd0)   begin n_fail++; $display("FAIL rst_addr got %0d want 0", bus.rom_addr); end
      if (bus.pix_rgb !== 24'd0)    begin n_fail++; $display("FAIL rst_rgb got %h want 0", bus.pix_rgb); end
      if (bus.pix_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_valid got %b want 0", bus.pix_valid); end
      if (bus.busy !== 1'b0)        begin n_fail++; $display("FAIL rst_busy got %b want 0", bus.busy); end
      Reset_n = 1'b1;
      model_reset();
      tick();
   endtask

   task automatic test_fetch();
      pulse(99, 200, 100, 2, 0);
      check_fetch(2, 0, 0);
   endtask

   task automatic test_display();
      pulse(100, 200, 100, 2, 0);
      sweep(196, 272);
      probe(199, 1'b0, 24'h0, "edge_left");
      probe(200, 1'b1, rom_word(8704), "first_col");
      probe(268, 1'b0, 24'h0, "edge_right");
   endtask

   task automatic test_key();
      int sx = $urandom_range(50, 500);
      int sy = $urandom_range(1, 400);
      int fr = $urandom_range(0, 3);
      int r  = $urandom_range(0, 63);
      wait_idle();
      key_col = 5;
      pulse(sy + r - 1, sx, sy, fr, 0);
      wait_idle();
      pulse(600 - 1, sx, sy, fr, 0);
      sweep(sx - 2, sx + 70);
      probe(sx + 5, 1'b0, 24'h0, "key_col");
      probe(sx + 4, 1'b1, rom_word(fr * 4352 + r * 68 + 4), "key_left");
      probe(sx + 6, 1'b1, rom_word(fr * 4352 + r * 68 + 6), "key_right");
      key_col = -1;
   endtask

   task automatic test_abort();
      int sx = $urandom_range(0, 560);
      wait_idle();
      pulse(149, sx, 120, 1, 0);
      repeat (30) tick();
      pulse(150, sx, 120, 3, 0);
      check_fetch(3, 31, 0);
      sweep(sx - 2, sx + 70);
      pulse(0, sx, 300, 0, 0);
      sweep(sx - 2, sx + 70);
   endtask

   task automatic test_wrap();
      int fr = $urandom_range(0, 3);
      int sx = $urandom_range(0, 560);
      wait_idle();
      pulse(524, sx, 0, fr, 0);
      check_fetch(fr, 0, 0);
`ifdef COP_SPRITE_MIRROR_EN
      pulse(524, sx, 0, fr, 1);
      check_fetch(fr, 0, 1);
`endif
      pulse(0, sx, 400, 0, 0);
      sweep(sx - 2, sx + 70);
   endtask

   task automatic test_reset_mid_fetch();
      int sx = $urandom_range(0, 560);
      wait_idle();
      pulse(40, sx, 30, 2, 0);
      bus.DrawX = 10'(m_sx + 3);
      repeat (20) tick();
      #2 Reset_n = 1'b0;
      #1;
      n_chk += 3;
      if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
      if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", bus.pix_valid); end
      if (bus.rom_addr !== 15'd0) begin n_fail++; $display("FAIL midrst_addr got %0d want 0", bus.rom_addr); end
      model_reset();
      tick();
      Reset_n = 1'b1;
      tick();
      n_chk++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_restart got busy=%b want 0", bus.busy); end
      pulse(0, sx, 300, 0, 0);
      sweep(sx - 2, sx + 70);
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         int sy  = $urandom_range(0, 460);
         int tgt = ($urandom_range(0, 3) != 0) ? sy + $urandom_range(0, 63) : $urandom_range(0, 524);
         int sx  = $urandom_range(0, 700);
         int g   = $urandom_range(60, 75);
         pulse((tgt == 0) ? 524 : tgt - 1, sx, sy, $urandom_range(0, 3), $urandom_range(0, 1));
         repeat (g) tick();
         sy  = $urandom_range(0, 460);
         tgt = sy + $urandom_range(0, 63);
         pulse((tgt == 0) ? 524 : tgt - 1, sx, sy, $urandom_range(0, 3), $urandom_range(0, 1));
         sweep(sx - 2, sx + 70);
      end
   endtask

   initial begin
      bus.line_start = 1'b0; bus.DrawX = '0; bus.DrawY = '0;
      bus.spr_x = '0; bus.spr_y = '0; bus.frame_sel = '0;
`ifdef COP_SPRITE_MIRROR_EN
      bus.mirror = 1'b0;
`endif
      model_reset();
      last_pulse = 0;
      test_reset();
      test_fetch();
      test_display();
      test_key();
      test_abort();
      test_wrap();
      test_reset_mid_fetch();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
endmodule
